sandbox_serializer: RTL and testbench

- Parallel-to-serial transmitter for the sandbox datapath.
- Accepts DATA_WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock, with frame and last-bit strobes.
- Enforces a programmable idle gap between frames.
- Forms the transmit end of the sandbox serial link; a matching deserializer captures o_sdata under o_sframe.

---
 rtl/sandbox_pkg.sv | 22 ++
 rtl/sandbox_serializer.sv | 161 ++++++++++++++++
 tb/tb_sandbox_serializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sandbox_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sandbox_pkg                                               |
// | Purpose  : Shared types and helpers for the sandbox serial link.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sandbox_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_GAP   = 2'd2
  } ser_state_e;

  // Width of a down-counter that must hold the value n-1, never less than 1 bit
  function automatic int ser_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sandbox_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sandbox_serializer                                        |
// | Purpose  : Parallel-to-serial transmitter with frame/last strobes    |
// |            and a programmable idle gap between frames.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sandbox_serializer
  import sandbox_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic                  o_sdata,
  output logic                  o_sframe,
  output logic                  o_slast,
  output logic                  o_busy
);

  localparam int c_bit_w = ser_cnt_width(DATA_WIDTH);
  localparam int c_gap_w = ser_cnt_width(GAP_CYCLES + 1);

  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);
  localparam logic [c_bit_w-1:0] c_bit_zero = '0;
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES);
  localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);

  ser_state_e              r_state;
  ser_state_e              w_state_n;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [DATA_WIDTH-1:0]   w_shreg_n;
  logic [c_bit_w-1:0]      r_bcnt;
  logic [c_bit_w-1:0]      w_bcnt_n;
  logic [c_gap_w-1:0]      r_gcnt;
  logic [c_gap_w-1:0]      w_gcnt_n;
  logic                    w_sdata_n;
  logic                    w_sframe_n;
  logic                    w_slast_n;
  logic                    w_accept;

  // The shift register holds the bits still to be sent, with the next one
  // parked at the transmit end (MSB for MSB-first, LSB otherwise).
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  // Ready in IDLE and in the single cycle right before the earliest legal next bit
  always_comb begin
    o_ready = 1'b0;
    if (i_reset_n) begin
      case (r_state)
        SER_IDLE:  o_ready = 1'b1;
        SER_SHIFT: o_ready = (GAP_CYCLES == 0) && (r_bcnt == c_bit_zero);
        SER_GAP:   o_ready = (r_gcnt == c_gap_one);
        default:   o_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = i_valid && o_ready;

  // Next state, next shift/counter contents and next registered outputs
  always_comb begin
    w_state_n  = r_state;
    w_shreg_n  = r_shreg;
    w_bcnt_n   = r_bcnt;
    w_gcnt_n   = r_gcnt;
    w_sdata_n  = 1'b0;
    w_sframe_n = 1'b0;
    w_slast_n  = 1'b0;

    case (r_state)
      SER_IDLE: begin
        if (w_accept) begin
          w_state_n  = SER_SHIFT;
          w_shreg_n  = drop_bit(i_d);
          w_bcnt_n   = c_bit_last;
          w_sdata_n  = first_bit(i_d);
          w_sframe_n = 1'b1;
        end
      end

      SER_SHIFT: begin
        if (r_bcnt != c_bit_zero) begin
          w_shreg_n  = drop_bit(r_shreg);
          w_bcnt_n   = r_bcnt - c_bit_one;
          w_sdata_n  = first_bit(r_shreg);
          w_sframe_n = 1'b1;
          w_slast_n  = (r_bcnt == c_bit_one);
        end else if (GAP_CYCLES == 0) begin
          // Gapless: the next word may start right after the last bit
          if (w_accept) begin
            w_shreg_n  = drop_bit(i_d);
            w_bcnt_n   = c_bit_last;
            w_sdata_n  = first_bit(i_d);
            w_sframe_n = 1'b1;
          end else begin
            w_state_n  = SER_IDLE;
          end
        end else begin
          w_state_n = SER_GAP;
          w_gcnt_n  = c_gap_load;
        end
      end

      SER_GAP: begin
        if (r_gcnt == c_gap_one) begin
          if (w_accept) begin
            w_state_n  = SER_SHIFT;
            w_shreg_n  = drop_bit(i_d);
            w_bcnt_n   = c_bit_last;
            w_sdata_n  = first_bit(i_d);
            w_sframe_n = 1'b1;
          end else begin
            w_state_n  = SER_IDLE;
          end
        end else begin
          w_gcnt_n = r_gcnt - c_gap_one;
        end
      end

      default: w_state_n = SER_IDLE;
    endcase
  end

  // State, datapath and output registers; reset drops any frame in flight
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= SER_IDLE;
      r_shreg  <= '0;
      r_bcnt   <= '0;
      r_gcnt   <= '0;
      o_sdata  <= 1'b0;
      o_sframe <= 1'b0;
      o_slast  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shreg  <= w_shreg_n;
      r_bcnt   <= w_bcnt_n;
      r_gcnt   <= w_gcnt_n;
      o_sdata  <= w_sdata_n;
      o_sframe <= w_sframe_n;
      o_slast  <= w_slast_n;
      o_busy   <= (w_state_n != SER_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sandbox_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sandbox_serializer                                     |
// | Purpose  : Self-checking bench; four serializer instances with       |
// |            different bit orders and gaps against a schedule model.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sandbox_serializer;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] din [4];
  logic [3:0] ready, sdata, sframe, slast, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance configuration: 0 = MSB/gap1, 1 = LSB/gap1, 2 = MSB/gap0, 3 = MSB/gap3
  function automatic int cfg_msb(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_gap(input int i);
    case (i)
      2:       return 0;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  sandbox_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]), .i_d(din[0]),
    .o_sdata(sdata[0]), .o_sframe(sframe[0]), .o_slast(slast[0]), .o_busy(busy[0]));
  sandbox_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]), .i_d(din[1]),
    .o_sdata(sdata[1]), .o_sframe(sframe[1]), .o_slast(slast[1]), .o_busy(busy[1]));
  sandbox_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[2]), .o_ready(ready[2]), .i_d(din[2]),
    .o_sdata(sdata[2]), .o_sframe(sframe[2]), .o_slast(slast[2]), .o_busy(busy[2]));
  sandbox_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid[3]), .o_ready(ready[3]), .i_d(din[3]),
    .o_sdata(sdata[3]), .o_sframe(sframe[3]), .o_slast(slast[3]), .o_busy(busy[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: a per-cycle schedule of expected serial outputs, filled when a word
  // is accepted; ready/busy follow from the next-allowed and busy-until cycles.
  int cyc = 0;
  bit chk_en = 1'b0;
  bit ef [4][0:1023];
  bit ed [4][0:1023];
  bit el [4][0:1023];
  int nr [4];
  int busy_until [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        for (int u = cyc + 1; u <= cyc + 40; u++) begin
          ef[i][u] = 1'b0;
          ed[i][u] = 1'b0;
          el[i][u] = 1'b0;
        end
        nr[i] = cyc + 1;
        busy_until[i] = cyc;
      end else if (chk_en && valid[i] && cyc >= nr[i]) begin
        for (int k = 0; k < DW; k++) begin
          ef[i][cyc + 1 + k] = 1'b1;
          ed[i][cyc + 1 + k] = din[i][(cfg_msb(i) != 0) ? (DW - 1 - k) : k];
          el[i][cyc + 1 + k] = (k == DW - 1);
        end
        nr[i] = cyc + DW + cfg_gap(i);
        busy_until[i] = cyc + DW + cfg_gap(i);
      end
    end
    if (!rst_n) chk_en = 1'b1;
    cyc = cyc + 1;
  end

  // Compare every instance against the model on every cycle after the first reset edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("m%0d.ready", i),  ready[i],  32'(rst_n && (cyc >= nr[i])));
          chk($sformatf("m%0d.sframe", i), sframe[i], 32'(ef[i][cyc]));
          chk($sformatf("m%0d.sdata", i),  sdata[i],  32'(ed[i][cyc]));
          chk($sformatf("m%0d.slast", i),  slast[i],  32'(el[i][cyc]));
          chk($sformatf("m%0d.busy", i),   busy[i],   32'(cyc <= busy_until[i]));
        end
      end
    end
  end

  // Directed stimulus with hand-computed literal expectations
  initial begin
    logic [7:0] pat;
    rst_n  = 1'b0;
    valid  = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = 8'h5A;

    // Reset held with valid high: nothing ready, all outputs quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",  ready,  4'h0);
    chk("rst.sframe", sframe, 4'h0);
    chk("rst.sdata",  sdata,  4'h0);
    chk("rst.busy",   busy,   4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = 4'h0;
    @(negedge clk);
    chk("release.ready", ready, 4'hF);

    // Single word MSB-first 0xA5 on inst0, LSB-first 0x01 on inst1
    @(posedge clk); #1;
    valid  = 4'b0011;
    din[0] = 8'hA5;
    din[1] = 8'h01;
    @(posedge clk); #1;
    valid  = 4'h0;
    pat    = 8'b1010_0101;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2.bit",   sdata[0],  pat[8 - k]);
      chk("t2.frame", sframe[0], 1'b1);
      chk("t2.last",  slast[0],  32'(k == 8));
      chk("t3.bit",   sdata[1],  32'(k == 1));
    end
    @(negedge clk);
    chk("t2.ready9", ready[0],  1'b1);
    chk("t2.frame9", sframe[0], 1'b0);
    repeat (4) @(posedge clk);

    // Back-to-back on inst2 (gap 0) and gap enforcement on inst3 (gap 3)
    @(posedge clk); #1;
    valid[2] = 1'b1; din[2] = 8'hFF;
    valid[3] = 1'b1; din[3] = 8'hC3;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 15) chk("t4.ready", ready[2], 32'(k == 0 || k == 8));
      chk("t4.frame", sframe[2], 32'(k >= 1 && k <= 16));
      chk("t4.last",  slast[2],  32'(k == 8 || k == 16));
      chk("t4.bit",   sdata[2],  32'(k >= 1 && k <= 8));
      chk("t5.ready", ready[3],  32'(k == 0 || k == 11));
      chk("t5.frame", sframe[3], 32'((k >= 1 && k <= 8) || (k >= 12 && k <= 19)));
      @(posedge clk); #1;
      if (k + 1 == 1)  din[2] = 8'h00;
      if (k + 1 == 9)  valid[2] = 1'b0;
      if (k + 1 == 12) valid[3] = 1'b0;
    end
    repeat (4) @(posedge clk);

    // Reset during the 4th bit of 0x3C, then a clean 0x81 from IDLE
    @(posedge clk); #1;
    valid[0] = 1'b1; din[0] = 8'h3C;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6.bit4",   sdata[0],  1'b1);
    chk("t6.frame4", sframe[0], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6.frame", sframe[0], 1'b0);
    chk("t6.busy",  busy[0],   1'b0);
    chk("t6.ready", ready[0],  1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6.nolast", slast[0], 1'b0);
    end
    @(posedge clk); #1;
    valid[0] = 1'b1; din[0] = 8'h81;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    pat = 8'b1000_0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t6.bit",  sdata[0], pat[8 - k]);
      chk("t6.last", slast[0], 32'(k == 8));
    end
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
